// File: rtl/serializer_stream_if.sv
// Handshake bundle for the parallel-to-serial stream: wide word in, framed D-bit slices out.
// The producer/consumer side uses master; the serializer uses slave.
interface serializer_stream_if #(
    parameter int D = 8,
    parameter int S = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [D*S-1:0] data_in;
    logic [D-1:0]   data_out;
    logic           out_valid;
    logic           out_first;
    logic           out_last;

    modport master (
        output in_valid, data_in,
        input  in_ready, data_out, out_valid, out_first, out_last
    );

    modport slave (
        input  in_valid, data_in,
        output in_ready, data_out, out_valid, out_first, out_last
    );
endinterface

// File: rtl/serializer_stream.sv
// Word-to-slice serializer: accepts D*S-bit words and emits S framed D-bit slices,
// with a one-word holding buffer so consecutive words stream without a bubble.
module serializer_stream #(
    parameter int D         = 8,
    parameter int S         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               high_speed_clock,
    input  logic               reset,
    serializer_stream_if.slave bus
);
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(S - 1);

    logic [D*S-1:0] active_q;
    logic [D*S-1:0] hold_q;
    logic           busy_q;
    logic           hold_valid_q;
    logic [CW-1:0]  cnt_q;

    logic [D-1:0]   data_q;
    logic           valid_q;
    logic           first_q;
    logic           last_q;

    logic           lastslot;
    logic           accept;
    logic [CW-1:0]  slot;
    logic [D-1:0]   slice_sel;

    assign lastslot     = busy_q && (cnt_q == LAST_CNT);
    assign bus.in_ready = !hold_valid_q && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign slot         = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);

    // Explicit compare per slice keeps the mux legal for any S, including non-powers of two.
    always_comb begin
        slice_sel = '0;
        for (int i = 0; i < S; i++) begin
            if (slot == CW'(i)) slice_sel = active_q[i*D +: D];
        end
    end

    always_ff @(posedge high_speed_clock) begin
        if (reset) begin
            busy_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            if (busy_q && !lastslot) cnt_q <= cnt_q + CW'(1);

            if (lastslot) begin
                if (hold_valid_q) begin
                    active_q     <= hold_q;
                    hold_valid_q <= 1'b0;
                    cnt_q        <= '0;
                end else if (!accept) begin
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                end
            end

            // An accept at lastslot only happens with the hold empty, so it wins cleanly here.
            if (accept) begin
                if (!busy_q || lastslot) begin
                    active_q <= bus.data_in;
                    cnt_q    <= '0;
                    busy_q   <= 1'b1;
                end else begin
                    hold_q       <= bus.data_in;
                    hold_valid_q <= 1'b1;
                end
            end

            valid_q <= busy_q;
            data_q  <= busy_q ? slice_sel : '0;
            first_q <= busy_q && (cnt_q == '0);
            last_q  <= lastslot;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_serializer_stream.sv
// Scoreboard bench: drivers push expected slices with their due cycle, monitors pop on out_valid.
module tb_serializer_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serializer_stream_if #(.D(8),  .S(4)) b0 ();
    serializer_stream_if #(.D(8),  .S(4)) b1 ();
    serializer_stream_if #(.D(16), .S(1)) b2 ();

    serializer_stream #(.D(8),  .S(4), .LSB_FIRST(1'b1)) u0 (.high_speed_clock(clk), .reset(rst), .bus(b0.slave));
    serializer_stream #(.D(8),  .S(4), .LSB_FIRST(1'b0)) u1 (.high_speed_clock(clk), .reset(rst), .bus(b1.slave));
    serializer_stream #(.D(16), .S(1), .LSB_FIRST(1'b1)) u2 (.high_speed_clock(clk), .reset(rst), .bus(b2.slave));

    // u1 runs in lockstep with u0 on the same words, only the slice order differs.
    assign b1.in_valid = b0.in_valid;
    assign b1.data_in  = b0.data_in;

    typedef struct {
        logic [15:0] d;
        logic        f;
        logic        l;
        int          c;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int cyc = 0;
    int checks = 0, failures = 0;
    int end01 = 0, end2 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic mon_step(input string nm, input logic v, input logic [15:0] d, input logic f,
                            input logic l, input int qsz, input exp_t h, output bit do_pop);
        do_pop = 1'b0;
        if (v) begin
            if (qsz == 0) cmp({nm, "_unexpected_slice"}, 32'd1, 32'd0);
            else begin
                cmp({nm, "_data"},  32'(d), 32'(h.d));
                cmp({nm, "_first"}, 32'(f), 32'(h.f));
                cmp({nm, "_last"},  32'(l), 32'(h.l));
                cmp({nm, "_cycle"}, cyc,    h.c);
                do_pop = 1'b1;
            end
        end else begin
            cmp({nm, "_idle_zero"}, {14'd0, d, f, l}, 32'd0);
            if (qsz > 0 && h.c <= cyc) begin
                cmp({nm, "_valid"}, 32'(v), 32'd1);
                do_pop = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t h;
        bit p;
        if (cyc > 1) begin
            h = '{default: 0};
            if (q0.size() > 0) h = q0[0];
            mon_step("u0", b0.out_valid, 16'(b0.data_out), b0.out_first, b0.out_last, q0.size(), h, p);
            if (p) void'(q0.pop_front());
            h = '{default: 0};
            if (q1.size() > 0) h = q1[0];
            mon_step("u1", b1.out_valid, 16'(b1.data_out), b1.out_first, b1.out_last, q1.size(), h, p);
            if (p) void'(q1.pop_front());
            h = '{default: 0};
            if (q2.size() > 0) h = q2[0];
            mon_step("u2", b2.out_valid, b2.data_out, b2.out_first, b2.out_last, q2.size(), h, p);
            if (p) void'(q2.pop_front());
        end
    end

    // Drive one word into u0/u1; returns the edge number at which it was accepted.
    task automatic send01(input logic [31:0] w, output int acc);
        int start;
        bit ok = 1'b0;
        b0.in_valid = 1'b1;
        b0.data_in  = w;
        for (int t = 0; t < 50; t++) begin
            if (b0.in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        cmp("u01_ready_wait", 32'(ok), 32'd1);
        cmp("u01_ready_lockstep", 32'(b1.in_ready), 32'(b0.in_ready));
        @(posedge clk); #1;
        acc = cyc;
        b0.in_valid = 1'b0;
        start = (acc + 1 > end01 + 1) ? acc + 1 : end01 + 1;
        for (int j = 0; j < 4; j++) begin
            q0.push_back('{16'(w[j*8 +: 8]),     j == 0, j == 3, start + j});
            q1.push_back('{16'(w[(3-j)*8 +: 8]), j == 0, j == 3, start + j});
        end
        end01 = start + 3;
    endtask

    task automatic send2(input logic [15:0] w, output int acc);
        int start;
        bit ok = 1'b0;
        b2.in_valid = 1'b1;
        b2.data_in  = w;
        for (int t = 0; t < 50; t++) begin
            if (b2.in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        cmp("u2_ready_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        b2.in_valid = 1'b0;
        start = (acc + 1 > end2 + 1) ? acc + 1 : end2 + 1;
        q2.push_back('{w, 1'b1, 1'b1, start});
        end2 = start;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k1, k2, k3;
        rst = 1'b1;
        b0.in_valid = 1'b0; b0.data_in = '0;
        b2.in_valid = 1'b0; b2.data_in = '0;
        idle(2);
        cmp("rst_in_ready_u0", 32'(b0.in_ready), 32'd0);
        cmp("rst_in_ready_u2", 32'(b2.in_ready), 32'd0);
        cmp("rst_out_u0", {22'd0, b0.out_valid, b0.out_first, b0.out_last, b0.data_out}, 32'd0);
        cmp("rst_out_u2", {13'd0, b2.out_valid, b2.out_first, b2.out_last, b2.data_out}, 32'd0);
        rst = 1'b0;
        #1;
        cmp("post_rst_in_ready", 32'(b0.in_ready), 32'd1);

        // Single word from idle, both slice orders.
        send01(32'h44332211, k1);
        idle(8);

        // Back-to-back with in_valid held high across words.
        send01(32'h44332211, k1);
        send01(32'h88776655, k2);
        send01(32'hCCBBAA99, k3);
        cmp("b2b_accept2_edge", k2, k1 + 1);
        cmp("b2b_accept3_edge", k3, k1 + 5);
        idle(16);

        // Underrun: next word accepted two edges after the previous out_last.
        send01(32'h44332211, k1);
        while (cyc < end01 + 1) begin @(posedge clk); #1; end
        send01(32'h88776655, k2);
        cmp("underrun_accept_edge", k2, k1 + 6);
        idle(8);

        // Reset after the second slice, with a word sitting in the hold register.
        send01(32'h44332211, k1);
        send01(32'h88776655, k2);
        while (cyc < k1 + 2) begin @(posedge clk); #1; end
        rst = 1'b1;
        while (q0.size() > 0 && q0[$].c > cyc) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].c > cyc) void'(q1.pop_back());
        end01 = 0;
        #1;
        cmp("midrst_in_ready", 32'(b0.in_ready), 32'd0);
        idle(1);
        cmp("midrst_out_u0", {22'd0, b0.out_valid, b0.out_first, b0.out_last, b0.data_out}, 32'd0);
        cmp("midrst_out_u1", {22'd0, b1.out_valid, b1.out_first, b1.out_last, b1.data_out}, 32'd0);
        cmp("midrst_in_ready_held", 32'(b0.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        cmp("midrst_release_ready", 32'(b0.in_ready), 32'd1);
        send01(32'hDDCCBBAA, k1);
        idle(8);

        // S=1: every slice framed first+last, input never stalls.
        send2(16'h1234, k1);
        cmp("s1_ready_stays_high", 32'(b2.in_ready), 32'd1);
        send2(16'hABCD, k2);
        cmp("s1_accept_consecutive", k2, k1 + 1);
        cmp("s1_ready_after", 32'(b2.in_ready), 32'd1);

        for (int t = 0; t < 50; t++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            @(posedge clk); #1;
        end
        idle(2);
        cmp("drain_pending", q0.size() + q1.size() + q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
